// File: rtl/counter_arbiter.sv
// Round-robin owner of one external loadable up/down counter.
// Each granted run loads a start value, counts N steps, returns the count.
module counter_arbiter #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [WIDTH-1:0]  req_load0,
   input  logic [WIDTH-1:0]  req_load1,
   input  logic [1:0]        req_dir,
   input  logic [STEP_W-1:0] req_steps0,
   input  logic [STEP_W-1:0] req_steps1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [WIDTH-1:0]  result,
   output logic              busy,
   output logic [WIDTH-1:0]  cnt_load,
   output logic              cnt_load_en,
   output logic              cnt_chnge,
   output logic              cnt_en,
   input  logic [WIDTH-1:0]  cnt_value
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   state_t state, state_n;

   logic              lp;
   logic              idx;
   logic [WIDTH-1:0]  load_q;
   logic              dir_q;
   logic [STEP_W-1:0] steps_q;
   logic [STEP_W-1:0] step_cnt;

   logic [1:0]        elig;
   logic              grant_v;
   logic              grant_idx;
   logic [WIDTH-1:0]  sel_load;
   logic [STEP_W-1:0] sel_steps;

   // A requester finishing this cycle must not win again straight away.
   always_comb begin
      elig      = req & ~done;
      grant_v   = |elig;
      grant_idx = (elig == 2'b11) ? ~lp : elig[1];
      sel_load  = grant_idx ? req_load1 : req_load0;
      sel_steps = grant_idx ? req_steps1 : req_steps0;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (grant_v) state_n = LOAD;
         LOAD: state_n = (steps_q == '0) ? DONE : RUN;
         RUN:  if (step_cnt == STEP_W'(1)) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         lp          <= 1'b1;
         idx         <= 1'b0;
         load_q      <= '0;
         dir_q       <= 1'b0;
         steps_q     <= '0;
         step_cnt    <= '0;
         gnt         <= '0;
         done        <= '0;
         result      <= '0;
         busy        <= 1'b0;
         cnt_load    <= '0;
         cnt_load_en <= 1'b0;
         cnt_chnge   <= 1'b0;
         cnt_en      <= 1'b0;
      end else begin
         state <= state_n;
         done  <= '0;
         busy  <= (state_n != IDLE);

         if (state == IDLE && grant_v) begin
            idx     <= grant_idx;
            gnt     <= grant_idx ? 2'b10 : 2'b01;
            load_q  <= sel_load;
            dir_q   <= req_dir[grant_idx];
            steps_q <= sel_steps;
         end

         if (state == LOAD) step_cnt <= steps_q;
         if (state == RUN)  step_cnt <= step_cnt - STEP_W'(1);

         if (state == DONE) begin
            result    <= cnt_value;
            done[idx] <= 1'b1;
            gnt       <= '0;
            lp        <= idx;
         end

         // Strobes are registered from the next state so they line up
         // exactly with the LOAD and RUN cycles.
         cnt_load_en <= (state_n == LOAD);
         cnt_load    <= (state_n == LOAD) ? sel_load : '0;
         cnt_en      <= (state_n == RUN);
         cnt_chnge   <= (state_n == RUN) && dir_q;
      end
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural model of the
// external counter it drives.
module tb_counter_arbiter;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] req = '0;
   logic [3:0] req_load0 = '0;
   logic [3:0] req_load1 = '0;
   logic [1:0] req_dir = '0;
   logic [3:0] req_steps0 = '0;
   logic [3:0] req_steps1 = '0;
   logic [1:0] gnt;
   logic [1:0] done;
   logic [3:0] result;
   logic       busy;
   logic [3:0] cnt_load;
   logic       cnt_load_en;
   logic       cnt_chnge;
   logic       cnt_en;
   logic [3:0] cnt_value;

   int n_chk = 0;
   int n_pass = 0;

   counter_arbiter #(.WIDTH(4), .STEP_W(4)) dut (
      .CLK(CLK),
      .reset(reset),
      .req(req),
      .req_load0(req_load0),
      .req_load1(req_load1),
      .req_dir(req_dir),
      .req_steps0(req_steps0),
      .req_steps1(req_steps1),
      .gnt(gnt),
      .done(done),
      .result(result),
      .busy(busy),
      .cnt_load(cnt_load),
      .cnt_load_en(cnt_load_en),
      .cnt_chnge(cnt_chnge),
      .cnt_en(cnt_en),
      .cnt_value(cnt_value)
   );

   always #5 CLK = ~CLK;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) cnt_value <= '0;
      else if (cnt_load_en) cnt_value <= cnt_load;
      else if (cnt_en) cnt_value <= cnt_chnge ? cnt_value + 4'd1 : cnt_value - 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Called at the negedge of cycle 0, after req has been driven.
   task automatic run_chk(input string tag, input logic [1:0] who,
                          input int exp_cyc, input logic [3:0] exp_load,
                          input logic [3:0] exp_res, input int exp_en,
                          input int drop_cyc);
      int  cyc = 0;
      int  en = 0;
      bit  seen = 0;
      bit  bad = 0;
      while (!seen && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         if (cyc == 1) begin
            chk({tag, "_gnt"}, 32'(gnt), 32'(who));
            chk({tag, "_ld"}, {31'd0, cnt_load_en}, 32'd1);
            chk({tag, "_ldv"}, 32'(cnt_load), 32'(exp_load));
         end
         if (cnt_en && cnt_load_en) bad = 1;
         if (busy != (gnt != 2'b00)) bad = 1;
         if (cnt_chnge && !cnt_en) bad = 1;
         en += int'(cnt_en);
         if (cyc == drop_cyc) begin
            req       = '0;
            req_load0 = 4'd0;
            req_steps0 = 4'd1;
            req_dir   = 2'b00;
         end
         if (done != 2'b00) seen = 1;
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
         chk({tag, "_done"}, 32'(done), 32'(who));
         chk({tag, "_res"}, 32'(result), 32'(exp_res));
         chk({tag, "_en"}, 32'(en), 32'(exp_en));
         chk({tag, "_inv"}, {31'd0, bad}, 32'd0);
         chk({tag, "_gclr"}, 32'(gnt), 32'd0);
      end
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cnt", {28'd0, cnt_load_en, cnt_en, cnt_chnge, 1'b0}, 32'd0);
      chk("rst_res", 32'(result), 32'd0);
      reset = 1'b1;
      @(negedge CLK);

      // 12 up 3 -> 15
      req_load0 = 4'd12; req_dir = 2'b01; req_steps0 = 4'd3; req = 2'b01;
      run_chk("t1", 2'b01, 6, 4'd12, 4'd15, 3, 0);
      req = '0;
      @(negedge CLK);

      // 14 up 3 wraps to 1
      req_load0 = 4'd14; req_dir = 2'b01; req_steps0 = 4'd3; req = 2'b01;
      run_chk("t2a", 2'b01, 6, 4'd14, 4'd1, 3, 0);
      req = '0;

      // 1 down 2 wraps to 15
      req_load1 = 4'd1; req_dir = 2'b00; req_steps1 = 4'd2; req = 2'b10;
      run_chk("t2b", 2'b10, 5, 4'd1, 4'd15, 2, 0);
      req = '0;
      @(negedge CLK);

      // load only
      req_load0 = 4'd9; req_dir = 2'b01; req_steps0 = 4'd0; req = 2'b01;
      run_chk("t4", 2'b01, 3, 4'd9, 4'd9, 0, 0);
      req = '0;
      @(negedge CLK);

      // drop req and scramble operands in the 2nd RUN cycle
      req_load0 = 4'd5; req_dir = 2'b01; req_steps0 = 4'd4; req = 2'b01;
      run_chk("t6", 2'b01, 7, 4'd5, 4'd9, 4, 3);
      @(negedge CLK);

      // asynchronous reset in the middle of a long run
      req_load1 = 4'd2; req_dir = 2'b10; req_steps1 = 4'd10; req = 2'b10;
      repeat (4) @(negedge CLK);
      chk("t5_pre_en", {31'd0, cnt_en}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t5_gnt", 32'(gnt), 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_en", {30'd0, cnt_en, cnt_chnge}, 32'd0);
      req = '0;
      repeat (2) @(negedge CLK);
      chk("t5_done", 32'(done), 32'd0);
      reset = 1'b1;
      @(negedge CLK);

      // both requesting: 0 first after reset, then alternate
      req_load0 = 4'd3; req_load1 = 4'd8; req_dir = 2'b01;
      req_steps0 = 4'd1; req_steps1 = 4'd1; req = 2'b11;
      run_chk("t3a", 2'b01, 4, 4'd3, 4'd4, 1, 0);
      run_chk("t3b", 2'b10, 4, 4'd8, 4'd7, 1, 0);
      run_chk("t3c", 2'b01, 4, 4'd3, 4'd4, 1, 0);
      run_chk("t3d", 2'b10, 4, 4'd8, 4'd7, 1, 0);
      req = '0;
      repeat (2) @(negedge CLK);
      chk("t3_idle", 32'(gnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Controller that shares one 4-bit loadable up/down counter between two requesters.
- Each request is a "run": load a start value, then count N steps up or down.
- The block arbitrates round-robin, sequences the counter's load/chnge/enable inputs through a small FSM, and returns the final count to the winning requester.
- Sits between the requester logic and the counter instance; the counter itself is external.

Parameters:
- WIDTH, 4, counter data width (load value, cnt_value, result).
- STEP_W, 4, width of the per-request step count.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  request per requester (bit 0 = requester 0).
- req_load0  in  WIDTH  start value, requester 0.
- req_load1  in  WIDTH  start value, requester 1.
- req_dir  in  2  count direction per requester; 1 = up, 0 = down.
- req_steps0  in  STEP_W  step count, requester 0; 0 = load only.
- req_steps1  in  STEP_W  step count, requester 1.
- gnt  out  2  one-hot grant; held for the whole run.
- done  out  2  one-cycle completion pulse per requester.
- result  out  WIDTH  counter value at end of last run; valid with done.
- busy  out  1  high whenever FSM is not IDLE.
- cnt_load  out  WIDTH  load value driven to the counter.
- cnt_load_en  out  1  counter load strobe.
- cnt_chnge  out  1  counter direction; 1 = up.
- cnt_en  out  1  counter count enable.
- cnt_value  in  WIDTH  registered counter output, updates on the edge after cnt_en or cnt_load_en.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; gnt, done, result, busy and all cnt_* outputs = 0; last-grant pointer lp=1, so requester 0 wins the first tie.
- Request handshake:
  - A requester holds req high with its operands stable until its done pulse.
  - It deasserts req in the done cycle or later.
  - Operands are latched at grant; later changes are ignored.
  - Dropping req mid-run does not abort the run; it completes and done still pulses.
- Arbitration (IDLE only):
  - Eligible = req & ~done; a requester pulsing done this cycle is excluded.
  - If both are eligible, grant the one that is not lp; otherwise grant the single eligible requester.
  - No eligible requester: stay in IDLE.
- FSM states:
  - IDLE: on a grant, latch load/dir/steps into internal registers, set gnt, go to LOAD.
  - LOAD (1 cycle): cnt_load_en=1, cnt_load=latched value. steps==0 -> DONE; else step counter=steps -> RUN.
  - RUN: cnt_en=1, cnt_chnge=latched dir; step counter decrements each cycle. When the counter reaches 1 (last enable cycle) -> DONE. Exactly `steps` enable cycles are issued.
  - DONE (1 cycle): all cnt_* outputs 0. On exit, register result<=cnt_value, assert done[granted] for one cycle, clear gnt, set lp=granted index, go to IDLE.
- Output timing:
  - cnt_load_en, cnt_en and cnt_chnge are registered, decoded from state and asserted only in their state.
  - cnt_chnge=0 outside RUN.
- Latency, with req sampled in IDLE at cycle 0:
  - gnt visible from cycle 1.
  - done and result in cycle steps+3.
  - steps=0 gives done in cycle 3.
  - The next grant can be made in the done cycle, to the other requester only.
- Arithmetic: the counter wraps modulo 2^WIDTH. The block does no arithmetic on data; result is the captured cnt_value.
- Invariants:
  - gnt is one-hot or zero.
  - done only for the granted index.
  - cnt_load_en and cnt_en never high together.
  - busy == (gnt != 0).
- Reset mid-run: everything is cleared immediately; no done pulse is issued for the aborted run.

Test Plan:
1. After reset release, req=01, load0=12, dir up, steps=3 -> cnt_load_en 1 cycle with cnt_load=12, then cnt_en for 3 cycles, done[0] at cycle 6, result=15.
2. req0 load=14, up, steps=3 -> counter wraps; result=1. req1 load=1, down, steps=2 -> result=15 (underflow wrap).
3. req=11 held continuously, each requester re-requesting after done -> grants alternate 0,1,0,1. The first grant after reset goes to requester 0. The same requester is never granted twice while the other waits.
4. steps=0, load=9 -> LOAD then DONE, no cnt_en pulses, done in cycle 3, result=9.
5. reset pulled low during RUN of a steps=10 request -> all outputs 0 asynchronously, no done. After release, a new req is granted normally.
6. req0 dropped in the 2nd RUN cycle, and req_load0 changed mid-run -> run completes using the latched operands; done[0] still pulses with the correct result.
